// File: rtl/avalon_mem_slave_adapter.sv
// Avalon-MM slave to req/gnt + rvalid memory port bridge.
// Watchdog forces completion so a dead target cannot stall the core.
module avalon_mem_slave_adapter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] avs_addr,
    input  logic [3:0]  avs_byteenable,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        timeout_err,
    output logic [15:0] timeout_count
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] watchdog;
    logic        wd_expired;
    logic        cmd_seen;

    assign wd_expired = (watchdog == WD_LAST);
    assign cmd_seen   = avs_read | avs_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            watchdog        <= '0;
            avs_readdata    <= '0;
            avs_waitrequest <= 1'b1;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_be          <= '0;
            mem_wdata       <= '0;
            timeout_err     <= 1'b0;
            timeout_count   <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    avs_waitrequest <= 1'b1;
                    avs_readdata    <= '0;
                    if (cmd_seen) begin
                        // read has priority when both strobes are high
                        mem_we    <= ~avs_read;
                        mem_addr  <= avs_addr;
                        mem_be    <= avs_byteenable;
                        mem_wdata <= avs_writedata;
                        mem_req   <= 1'b1;
                        watchdog  <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        watchdog <= watchdog + 16'd1;
                        if (mem_we) begin
                            avs_waitrequest <= 1'b0;
                            avs_readdata    <= '0;
                            state           <= DONE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end else if (wd_expired) begin
                        mem_req         <= 1'b0;
                        avs_waitrequest <= 1'b0;
                        avs_readdata    <= mem_we ? 32'd0 : TIMEOUT_DATA;
                        timeout_err     <= 1'b1;
                        if (timeout_count != 16'hFFFF)
                            timeout_count <= timeout_count + 16'd1;
                        state           <= DONE;
                    end else begin
                        watchdog <= watchdog + 16'd1;
                    end
                end
                WAIT_RD: begin
                    if (mem_rvalid) begin
                        avs_readdata    <= mem_rdata;
                        avs_waitrequest <= 1'b0;
                        state           <= DONE;
                    end else if (wd_expired) begin
                        avs_readdata    <= TIMEOUT_DATA;
                        avs_waitrequest <= 1'b0;
                        timeout_err     <= 1'b1;
                        if (timeout_count != 16'hFFFF)
                            timeout_count <= timeout_count + 16'd1;
                        state           <= DONE;
                    end else begin
                        watchdog <= watchdog + 16'd1;
                    end
                end
                DONE: begin
                    avs_waitrequest <= 1'b1;
                    avs_readdata    <= '0;
                    state           <= IDLE;
                end
                default: begin
                    avs_waitrequest <= 1'b1;
                    mem_req         <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mem_slave_adapter.sv
// Directed bench for avalon_mem_slave_adapter with an expected-result queue.
module tb_avalon_mem_slave_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] avs_addr = '0;
    logic [3:0]  avs_byteenable = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        timeout_err;
    logic [15:0] timeout_count;

    avalon_mem_slave_adapter #(
        .TIMEOUT_CYCLES(8),
        .TIMEOUT_DATA  (32'hDEADBEEF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .avs_addr       (avs_addr),
        .avs_byteenable (avs_byteenable),
        .avs_read       (avs_read),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .timeout_err    (timeout_err),
        .timeout_count  (timeout_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int unsigned t0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] rdata, input logic to);
        exp_t e;
        avs_read       = rd;
        avs_write      = wr;
        avs_addr       = a;
        avs_byteenable = be;
        avs_writedata  = wd;
        e.we    = ~rd;
        e.addr  = a;
        e.be    = be;
        e.wdata = wd;
        e.rdata = rdata;
        e.to    = to;
        sb.push_back(e);
    endtask

    task automatic drop();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic issue_chk(input string tag);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sb[0];
            chk({tag, "_req"}, 32'(mem_req), 32'd1);
            chk({tag, "_we"}, 32'(mem_we), 32'(e.we));
            chk({tag, "_addr"}, mem_addr, e.addr);
            chk({tag, "_be"}, 32'(mem_be), 32'(e.be));
            chk({tag, "_wdata"}, mem_wdata, e.wdata);
            chk({tag, "_wait"}, 32'(avs_waitrequest), 32'd1);
        end
    endtask

    task automatic done_chk(input string tag);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wait"}, 32'(avs_waitrequest), 32'd0);
            chk({tag, "_rdata"}, avs_readdata, e.rdata);
            chk({tag, "_terr"}, 32'(timeout_err), 32'(e.to));
            chk({tag, "_req"}, 32'(mem_req), 32'd0);
        end
    endtask

    task automatic after_chk(input string tag);
        chk({tag, "_wait1"}, 32'(avs_waitrequest), 32'd1);
        chk({tag, "_rd0"}, avs_readdata, 32'd0);
        chk({tag, "_terr0"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_wait", 32'(avs_waitrequest), 32'd1);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_tcnt", 32'(timeout_count), 32'd0);
        rst = 1'b0;
        tick();

        // write, gnt on first ISSUE cycle
        t0 = cyc;
        cmd(1'b0, 1'b1, 32'h100, 4'b0011, 32'hA5A5_1234, 32'd0, 1'b0);
        tick();
        issue_chk("wr");
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("wr_lat", cyc - t0, 32'd2);
        done_chk("wr");
        tick();
        drop();
        after_chk("wr_post");

        // read, 2 stall cycles, rvalid 3 cycles after gnt
        cmd(1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0);
        tick();
        issue_chk("rd");
        tick();
        tick();
        chk("rd_hold", 32'(mem_req), 32'd1);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("rd_req_drop", 32'(mem_req), 32'd0);
        chk("rd_gnt_rv_ign", 32'(avs_waitrequest), 32'd1);
        tick();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        done_chk("rd");
        tick();
        drop();
        after_chk("rd_post");

        // read timeout, no gnt
        cmd(1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 32'hDEADBEEF, 1'b1);
        tick();
        issue_chk("to_rd");
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("to_rd_req%0d", i), 32'(mem_req), 32'd1);
            tick();
        end
        done_chk("to_rd");
        chk("to_rd_cnt", 32'(timeout_count), 32'd1);
        tick();
        drop();
        after_chk("to_rd_post");
        chk("to_rd_cnt2", 32'(timeout_count), 32'd1);

        // write timeout completes with zero data
        cmd(1'b0, 1'b1, 32'h180, 4'hF, 32'h1234_5678, 32'd0, 1'b1);
        tick();
        issue_chk("to_wr");
        repeat (8) tick();
        done_chk("to_wr");
        chk("to_wr_cnt", 32'(timeout_count), 32'd2);
        tick();
        drop();
        after_chk("to_wr_post");

        // rvalid coincident with watchdog expiry
        cmd(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 32'h1111_2222, 1'b0);
        tick();
        issue_chk("co");
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        repeat (6) tick();
        chk("co_wait", 32'(avs_waitrequest), 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        done_chk("co");
        chk("co_cnt", 32'(timeout_count), 32'd2);
        tick();
        drop();
        after_chk("co_post");

        // read and write together: read wins
        cmd(1'b1, 1'b1, 32'h40, 4'hF, 32'h7777_7777, 32'h5555_AAAA, 1'b0);
        tick();
        issue_chk("both");
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        done_chk("both");
        tick();
        chk("both_wait1", 32'(avs_waitrequest), 32'd1);
        t0 = cyc;
        cmd(1'b1, 1'b0, 32'h44, 4'h3, 32'h0, 32'h0BAD_F00D, 1'b0);
        tick();
        issue_chk("b2b");
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        tick();
        mem_rvalid = 1'b0;
        chk("b2b_lat", cyc - t0, 32'd3);
        done_chk("b2b");
        tick();
        drop();
        after_chk("b2b_post");

        // async reset while in WAIT_RD
        cmd(1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 32'h0, 1'b0);
        tick();
        issue_chk("ar");
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_wait", 32'(avs_waitrequest), 32'd1);
        chk("ar_req", 32'(mem_req), 32'd0);
        chk("ar_addr", mem_addr, 32'd0);
        chk("ar_rdata", avs_readdata, 32'd0);
        chk("ar_tcnt", 32'(timeout_count), 32'd0);
        sb.delete();
        #1;
        rst = 1'b0;
        drop();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h9999_9999;
        tick();
        mem_rvalid = 1'b0;
        chk("ar_rv_wait", 32'(avs_waitrequest), 32'd1);
        chk("ar_rv_rdata", avs_readdata, 32'd0);
        chk("ar_rv_req", 32'(mem_req), 32'd0);
        tick();
        chk("ar_idle_wait", 32'(avs_waitrequest), 32'd1);
        cmd(1'b0, 1'b1, 32'h600, 4'b1100, 32'h0F0F_0F0F, 32'd0, 1'b0);
        tick();
        issue_chk("ar_new");
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        done_chk("ar_new");
        tick();
        drop();
        after_chk("ar_new_post");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
